// File: rtl/bitblade_shift_accumulator.sv
// Purpose: accumulates shifted signed lane sums (or XNOR bit counts) per group and presents the total.
// Latency: the result is valid one cycle after the beat that carries IN_LAST.
// Backpressure: IN_READY drops while a result is held; OUT_READY releases it, and IN_READY rises again in the next cycle.
module bitblade_shift_accumulator #(
    parameter int LANES = 4,
    parameter int ACC_W = 24
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic                 IN_LAST,
    input  logic [LANES*6-1:0]   PROD,
    input  logic [3:0]           SHIFT,
    input  logic                 BIN,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [ACC_W-1:0]     OUT_ACC,
    output logic [3:0]           OUT_BEATS,
    output logic                 OUT_OVF
);

    localparam int SUM_W = 7 + $clog2(LANES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [3:0]         beats_q, beats_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_acc_q, out_acc_d;
    logic [3:0]         out_beats_q, out_beats_d;
    logic               out_ovf_q, out_ovf_d;

    logic [5:0]         lane_raw;
    logic [SUM_W-1:0]   lane_val;
    logic [SUM_W-1:0]   lane_sum;
    logic [ACC_W-1:0]   term;
    logic [ACC_W-1:0]   add_sum;
    logic               step_ovf;
    logic               accept;

    assign IN_READY  = (state_q != S_HOLD);
    assign accept    = IN_VALID && IN_READY;
    assign OUT_VALID = out_valid_q;
    assign OUT_ACC   = out_acc_q;
    assign OUT_BEATS = out_beats_q;
    assign OUT_OVF   = out_ovf_q;

    // Lane sum is wide enough that it can never wrap before the shift.
    always_comb begin
        lane_raw = '0;
        lane_val = '0;
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_raw = PROD[6*i +: 6];
            if (BIN) begin
                lane_val = {{(SUM_W-1){1'b0}}, lane_raw[0]};
            end else begin
                lane_val = {{(SUM_W-6){lane_raw[5]}}, lane_raw};
            end
            lane_sum = lane_sum + lane_val;
        end
        term     = {{(ACC_W-SUM_W){lane_sum[SUM_W-1]}}, lane_sum} << SHIFT;
        add_sum  = acc_q + term;
        step_ovf = (acc_q[ACC_W-1] == term[ACC_W-1]) && (add_sum[ACC_W-1] != acc_q[ACC_W-1]);
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        beats_d     = beats_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_acc_d   = out_acc_q;
        out_beats_d = out_beats_q;
        out_ovf_d   = out_ovf_q;
        case (state_q)
            S_IDLE, S_ACCUM: begin
                if (accept) begin
                    if (state_q == S_IDLE) begin
                        acc_d   = term;
                        beats_d = 4'd1;
                        ovf_d   = 1'b0;
                    end else begin
                        acc_d   = add_sum;
                        beats_d = (beats_q == 4'd15) ? 4'd15 : beats_q + 4'd1;
                        ovf_d   = ovf_q || step_ovf;
                    end
                    if (IN_LAST) begin
                        out_valid_d = 1'b1;
                        out_acc_d   = acc_d;
                        out_beats_d = beats_d;
                        out_ovf_d   = ovf_d;
                        state_d     = S_HOLD;
                    end else begin
                        state_d     = S_ACCUM;
                    end
                end
            end
            S_HOLD: begin
                if (OUT_READY) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            beats_q     <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            out_beats_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            beats_q     <= beats_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_acc_q   <= out_acc_d;
            out_beats_q <= out_beats_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_bitblade_shift_accumulator.sv
// Directed bench for bitblade_shift_accumulator with a queue of expected group results.
module tb_bitblade_shift_accumulator;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        IN_VALID;
    logic        IN_READY;
    logic        IN_LAST;
    logic [23:0] PROD;
    logic [3:0]  SHIFT;
    logic        BIN;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [23:0] OUT_ACC;
    logic [3:0]  OUT_BEATS;
    logic        OUT_OVF;

    typedef struct {
        logic [23:0] acc;
        logic [3:0]  beats;
        logic        ovf;
    } res_t;

    res_t   exp_q[$];
    int     checks   = 0;
    int     failures = 0;
    longint m_acc;
    int     m_beats;
    bit     m_ovf;
    bit     m_in_group;

    bitblade_shift_accumulator #(.LANES(4), .ACC_W(24)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_LAST(IN_LAST),
        .PROD(PROD), .SHIFT(SHIFT), .BIN(BIN),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_ACC(OUT_ACC), .OUT_BEATS(OUT_BEATS), .OUT_OVF(OUT_OVF)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic longint wrap24(input longint v);
        longint r;
        r = v & 64'hFFFFFF;
        if (r >= 64'h800000) r = r - 64'h1000000;
        return r;
    endfunction

    function automatic longint lane_value(input logic [5:0] p, input bit bin);
        longint v;
        v = longint'(p);
        if (bin) return longint'(p[0]);
        if (v >= 32) v = v - 64;
        return v;
    endfunction

    // Reference model: exact integer arithmetic, overflow when the true sum leaves the 24-bit range.
    task automatic model_beat(input logic [5:0] l0, input logic [5:0] l1, input logic [5:0] l2,
                              input logic [5:0] l3, input int sh, input bit bin, input bit last);
        longint t;
        longint raw;
        res_t   r;
        t = lane_value(l0, bin) + lane_value(l1, bin) + lane_value(l2, bin) + lane_value(l3, bin);
        t = wrap24(t * (longint'(1) << sh));
        if (!m_in_group) begin
            m_acc = t; m_beats = 1; m_ovf = 0; m_in_group = 1;
        end else begin
            raw = m_acc + t;
            if (raw > 64'sd8388607 || raw < -64'sd8388608) m_ovf = 1;
            m_acc = wrap24(raw);
            if (m_beats < 15) m_beats++;
        end
        if (last) begin
            r.acc = 24'(m_acc); r.beats = 4'(m_beats); r.ovf = m_ovf;
            exp_q.push_back(r);
            m_in_group = 0;
        end
    endtask

    task automatic drive(input logic [5:0] l0, input logic [5:0] l1, input logic [5:0] l2,
                         input logic [5:0] l3, input int sh, input bit bin, input bit last);
        IN_VALID = 1'b1;
        PROD     = {l3, l2, l1, l0};
        SHIFT    = 4'(sh);
        BIN      = bin;
        IN_LAST  = last;
    endtask

    task automatic send_beat(input logic [5:0] l0, input logic [5:0] l1, input logic [5:0] l2,
                             input logic [5:0] l3, input int sh, input bit bin, input bit last);
        int n;
        drive(l0, l1, l2, l3, sh, bin, last);
        n = 0;
        while (!IN_READY && n < 50) begin
            @(posedge CLK); #1; n++;
        end
        if (!IN_READY) check("in_ready_timeout", 32'(IN_READY), 32'd1);
        @(posedge CLK); #1;
        model_beat(l0, l1, l2, l3, sh, bin, last);
        IN_VALID = 1'b0;
    endtask

    task automatic collect(input string tag);
        int   n;
        res_t r;
        n = 0;
        while (!OUT_VALID && n < 50) begin
            @(posedge CLK); #1; n++;
        end
        check({tag, "_valid"}, 32'(OUT_VALID), 32'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd1);
        end else begin
            r = exp_q.pop_front();
            check({tag, "_acc"},   32'(OUT_ACC),   32'(r.acc));
            check({tag, "_beats"}, 32'(OUT_BEATS), 32'(r.beats));
            check({tag, "_ovf"},   32'(OUT_OVF),   32'(r.ovf));
        end
        OUT_READY = 1'b1;
        @(posedge CLK); #1;
        OUT_READY = 1'b0;
        check({tag, "_valid_clr"}, 32'(OUT_VALID), 32'd0);
        check({tag, "_in_ready"},  32'(IN_READY),  32'd1);
    endtask

    initial begin
        RESET_N = 1'b0; IN_VALID = 1'b0; IN_LAST = 1'b0; PROD = '0;
        SHIFT = '0; BIN = 1'b0; OUT_READY = 1'b0;
        m_acc = 0; m_beats = 0; m_ovf = 0; m_in_group = 0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_in_ready",  32'(IN_READY),  32'd1);
        check("rst_out_valid", 32'(OUT_VALID), 32'd0);
        check("rst_out_acc",   32'(OUT_ACC),   32'd0);
        check("rst_out_beats", 32'(OUT_BEATS), 32'd0);
        check("rst_out_ovf",   32'(OUT_OVF),   32'd0);
        RESET_N = 1'b1;
        @(posedge CLK); #1;
        check("post_rst_in_ready", 32'(IN_READY), 32'd1);

        // Single beat, lanes {1,2,3,4}
        send_beat(6'd1, 6'd2, 6'd3, 6'd4, 0, 1'b0, 1'b1);
        check("single_acc_literal", 32'(OUT_ACC), 32'd10);
        collect("single");

        // Signed shift: two beats of -4 lanes, shift 2, with an idle gap
        send_beat(6'b111100, 6'b111100, 6'b111100, 6'b111100, 2, 1'b0, 1'b0);
        repeat (2) @(posedge CLK);
        #1;
        send_beat(6'b111100, 6'b111100, 6'b111100, 6'b111100, 2, 1'b0, 1'b1);
        check("signed_acc_literal", 32'(OUT_ACC), 32'hFFFF80);
        collect("signed");

        // Binary mode
        send_beat(6'b111111, 6'b000000, 6'b000001, 6'b100001, 1, 1'b1, 1'b1);
        check("bin_acc_literal", 32'(OUT_ACC), 32'd6);
        collect("bin");

        // Mixed modes in one group
        send_beat(6'b111111, 6'd5, 6'd0, 6'b100000, 3, 1'b0, 1'b0);
        send_beat(6'b111110, 6'd1, 6'd3, 6'd1, 0, 1'b1, 1'b0);
        send_beat(6'd7, 6'd7, 6'd7, 6'd7, 15, 1'b0, 1'b1);
        collect("mixed");

        // Backpressure: held result, new beat waiting
        send_beat(6'd9, 6'd0, 6'd0, 6'd0, 4, 1'b0, 1'b1);
        drive(6'd1, 6'd1, 6'd1, 6'd1, 0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("bp_in_ready",  32'(IN_READY),  32'd0);
            check("bp_out_valid", 32'(OUT_VALID), 32'd1);
            check("bp_out_acc",   32'(OUT_ACC),   32'd144);
            @(posedge CLK); #1;
        end
        check("bp_beats", 32'(OUT_BEATS), 32'd1);
        void'(exp_q.pop_front());
        OUT_READY = 1'b1;
        @(posedge CLK); #1;
        OUT_READY = 1'b0;
        check("bp_valid_clr",    32'(OUT_VALID), 32'd0);
        check("bp_in_ready_up",  32'(IN_READY),  32'd1);
        @(posedge CLK); #1;
        model_beat(6'd1, 6'd1, 6'd1, 6'd1, 0, 1'b0, 1'b1);
        IN_VALID = 1'b0;
        check("bp_next_acc_literal", 32'(OUT_ACC), 32'd4);
        collect("bp_next");

        // Wrap and beat-count saturation
        for (int i = 0; i < 17; i++)
            send_beat(6'd31, 6'd31, 6'd31, 6'd31, 15, 1'b0, (i == 16));
        check("wrap_acc_literal",   32'(OUT_ACC),   32'h1E0000);
        check("wrap_beats_literal", 32'(OUT_BEATS), 32'd15);
        check("wrap_ovf_literal",   32'(OUT_OVF),   32'd1);
        collect("wrap");

        // Ovf must not leak into the next group
        send_beat(6'd2, 6'd0, 6'd0, 6'd0, 0, 1'b0, 1'b1);
        collect("after_wrap");

        // Reset mid-group discards the partial sum
        send_beat(6'd1, 6'd2, 6'd3, 6'd4, 0, 1'b0, 1'b0);
        send_beat(6'd1, 6'd2, 6'd3, 6'd4, 0, 1'b0, 1'b0);
        RESET_N = 1'b0;
        #2;
        check("midrst_in_ready",  32'(IN_READY),  32'd1);
        check("midrst_out_acc",   32'(OUT_ACC),   32'd0);
        check("midrst_out_beats", 32'(OUT_BEATS), 32'd0);
        m_in_group = 0;
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        send_beat(6'd5, 6'd0, 6'd0, 6'd0, 0, 1'b0, 1'b1);
        check("midrst_acc_literal", 32'(OUT_ACC), 32'd5);
        collect("midrst");

        // Reset while holding a result
        send_beat(6'd3, 6'd3, 6'd0, 6'd0, 0, 1'b0, 1'b1);
        void'(exp_q.pop_front());
        RESET_N = 1'b0;
        #2;
        check("holdrst_out_valid", 32'(OUT_VALID), 32'd0);
        check("holdrst_in_ready",  32'(IN_READY),  32'd1);
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        send_beat(6'd1, 6'd0, 6'd0, 6'd0, 1, 1'b0, 1'b1);
        collect("holdrst");

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bitblade_shift_accumulator.md
BITBLADE_SHIFT_ACCUMULATOR -- requirements
Module: bitblade_shift_accumulator

Interface
REQ-001 SHALL have parameters: LANES, default 4, number of 6-bit product lanes; ACC_W, default 24, accumulator width.
REQ-002 SHALL have ports as listed, one per line, with exactly these names, directions and widths:
- CLK  in  1  single clock; all state updates on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  beat present.
- IN_READY  out  1  block accepts a beat.
- IN_LAST  in  1  final beat of an accumulation group.
- PROD  in  LANES*6  lane products; lane i at [6i+5:6i], 6-bit two's complement.
- SHIFT  in  4  left-shift applied to this beat's lane sum (0..15).
- BIN  in  1  binary (XNOR) mode for this beat.
- OUT_VALID  out  1  result held.
- OUT_READY  in  1  consumer takes result.
- OUT_ACC  out  ACC_W  accumulated result, two's complement.
- OUT_BEATS  out  4  beats in group, saturating at 15.
- OUT_OVF  out  1  sticky: an accumulation step in the group wrapped.

Function
REQ-003 SHALL accept a beat only in a cycle where IN_VALID=1 and IN_READY=1; all other cycles SHALL leave accumulator state unchanged.
REQ-004 SHALL implement FSM states IDLE, ACCUM and HOLD.
REQ-005 IN_READY SHALL be 1 in IDLE and ACCUM and 0 in HOLD, including the HOLD cycle where OUT_READY=1.
REQ-006 BIN=0: lane value SHALL be the sign-extended 6-bit PROD lane; BIN=1: lane value SHALL be zero-extended PROD lane bit 0, with bits 5:1 ignored.
REQ-007 Beat term SHALL be (sum of LANES lane values, computed as signed, full width) << SHIFT, sign-extended to ACC_W.
REQ-008 Beat accepted in IDLE SHALL load acc <= term and beats <= 1, clear ovf, and go to ACCUM if IN_LAST=0.
REQ-009 Beat accepted in ACCUM SHALL set acc <= acc + term modulo 2^ACC_W and beats <= min(beats+1, 15).
REQ-010 On a wrapping add (signed overflow), ovf SHALL be set and stay set until the next group starts.
REQ-011 A beat with IN_LAST=1, from IDLE or ACCUM, SHALL be included in the sum.
REQ-012 On the next edge after that beat, OUT_ACC, OUT_BEATS and OUT_OVF SHALL show the final group values, OUT_VALID SHALL be 1, and state SHALL be HOLD (1-cycle latency).
REQ-013 In HOLD, OUT_ACC, OUT_BEATS and OUT_OVF SHALL stay stable while OUT_READY=0.
REQ-014 In HOLD, OUT_READY=1 SHALL clear OUT_VALID on the next edge and return to IDLE; IN_READY SHALL rise in that same next cycle.
REQ-015 Outside HOLD, OUT_VALID SHALL be 0; OUT_ACC SHALL keep its last presented value, and internal acc SHALL be separate from it.
REQ-016 Per-beat SHIFT and BIN SHALL apply to that beat only, so mixed modes within one group are legal.

Reset
REQ-017 RESET_N=0 SHALL, asynchronously, force state IDLE, OUT_VALID=0, OUT_ACC=0, OUT_BEATS=0, OUT_OVF=0, internal acc=0 and beats=0.
REQ-018 IN_READY SHALL equal 1 during and after reset.
REQ-019 Reset mid-group or in HOLD SHALL discard the partial group and the held result; the first beat after release SHALL start a new group.
REQ-020 Reset release SHALL take effect on the first CLK edge with RESET_N=1.

Verification
REQ-021 Single beat: PROD lanes {1,2,3,4}, SHIFT=0, BIN=0, IN_LAST=1 -> next cycle OUT_VALID=1, OUT_ACC=10, OUT_BEATS=1, OUT_OVF=0.
REQ-022 Signed shift: two beats, all lanes 6'b111100 (-4), SHIFT=2, LAST on beat 2 -> OUT_ACC=24'hFFFF80 (-128), OUT_BEATS=2.
REQ-023 Binary: BIN=1, lanes {6'b111111, 6'b000000, 6'b000001, 6'b100001}, SHIFT=1, LAST -> OUT_ACC=6.
REQ-024 Backpressure: result pending, OUT_READY=0 for 3 cycles with IN_VALID=1 -> IN_READY=0 and OUT_ACC constant; OUT_READY=1 -> OUT_VALID=0 next cycle, then a beat is accepted.
REQ-025 Wrap/saturation: 17 beats, lanes {31,31,31,31}, SHIFT=15 -> OUT_OVF=1, OUT_BEATS=15, OUT_ACC = modulo-2^24 sum.
REQ-026 Reset mid-group: 2 beats of 10 accepted, RESET_N pulsed low, then one beat of 5 with LAST -> OUT_ACC=5, OUT_BEATS=1.
